countdown_timer_bcd: RTL and testbench

//  Parametrised BCD countdown for the bomb game: M:SS.d display digits, tick prescaler,

---
 rtl/countdown_timer_bcd_if.sv | 26 ++
 rtl/countdown_timer_bcd.sv | 125 ++++++++++++
 tb/tb_countdown_timer_bcd.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_bcd_if.sv
// Control pulses and display/status outputs of the BCD countdown timer.
// The master side (key debouncers / bench) drives pulses; the timer is the slave.
interface countdown_timer_bcd_if;
  logic       START;
  logic       PAUSE;
  logic       PENALTY;
  logic [3:0] DECIMOS;
  logic [3:0] SEGUNDOS_UNIDADE;
  logic [3:0] SEGUNDOS_DECIMOS;
  logic [3:0] MINUTOS;
  logic       RUNNING;
  logic       WARNING;
  logic       TEMPO_ACABOU;

  modport master (
    output START, PAUSE, PENALTY,
    input  DECIMOS, SEGUNDOS_UNIDADE, SEGUNDOS_DECIMOS, MINUTOS,
    input  RUNNING, WARNING, TEMPO_ACABOU
  );

  modport slave (
    input  START, PAUSE, PENALTY,
    output DECIMOS, SEGUNDOS_UNIDADE, SEGUNDOS_DECIMOS, MINUTOS,
    output RUNNING, WARNING, TEMPO_ACABOU
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// M:SS.d countdown for the bomb game: tick prescaler, start/pause FSM, time penalty,
// low-time warning and expiry flag. Display digits are registered alongside the time.
module countdown_timer_bcd #(
  parameter int CLK_DIV        = 1,
  parameter int START_TENTHS   = 1200,
  parameter int PENALTY_TENTHS = 100,
  parameter int WARN_TENTHS    = 100
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  countdown_timer_bcd_if.slave  bus
);

  localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [12:0]     T_START    = 13'(START_TENTHS);
  localparam logic [13:0]     T_PENALTY  = 14'(PENALTY_TENTHS);
  localparam logic [12:0]     T_WARN     = 13'(WARN_TENTHS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // Mixed-radix split of tenths into {minutes, seconds tens, seconds units, tenths}.
  function automatic logic [15:0] to_digits(input logic [12:0] t);
    logic [12:0] secs;
    logic [12:0] mins;
    logic [12:0] sec_in_min;
    logic [12:0] sec_tens;
    logic [3:0]  d_tenths;
    logic [3:0]  d_units;
    secs       = t / 13'd10;
    d_tenths   = 4'(t - secs * 13'd10);
    mins       = secs / 13'd60;
    sec_in_min = secs - mins * 13'd60;
    sec_tens   = sec_in_min / 13'd10;
    d_units    = 4'(sec_in_min - sec_tens * 13'd10);
    return {4'(mins), 4'(sec_tens), d_units, d_tenths};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [12:0]   t_q, t_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   digits_q, digits_d;
  logic          tick;
  logic          counting;
  logic [13:0]   dec_amt;

  assign counting = (state_q == ST_RUN) || (state_q == ST_PAUSED);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    presc_d = presc_q;
    tick    = 1'b0;
    dec_amt = 14'd0;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        // Pausing freezes the prescaler, so no tick is taken on the pausing edge.
        if (bus.PAUSE) begin
          state_d = ST_PAUSED;
        end else if (presc_q == PRESC_LAST) begin
          tick    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      ST_PAUSED: begin
        if (bus.START && !bus.PAUSE) begin
          state_d = ST_RUN;
        end
      end
      default: begin
      end
    endcase

    if (counting) begin
      dec_amt = (bus.PENALTY ? T_PENALTY : 14'd0) + {13'd0, tick};
      if (dec_amt != 14'd0) begin
        // Saturate at zero; reaching zero by any path expires on this same edge.
        if ({1'b0, t_q} <= dec_amt) begin
          t_d     = '0;
          state_d = ST_EXPIRED;
        end else begin
          t_d = t_q - dec_amt[12:0];
        end
      end
    end

    digits_d = to_digits(t_d);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      t_q      <= T_START;
      presc_q  <= '0;
      digits_q <= to_digits(T_START);
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
    end
  end

  assign bus.MINUTOS          = digits_q[15:12];
  assign bus.SEGUNDOS_DECIMOS = digits_q[11:8];
  assign bus.SEGUNDOS_UNIDADE = digits_q[7:4];
  assign bus.DECIMOS          = digits_q[3:0];
  assign bus.RUNNING          = (state_q == ST_RUN);
  assign bus.WARNING          = counting && (t_q <= T_WARN);
  assign bus.TEMPO_ACABOU     = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench: default-parameter timer for countdown, penalty, FSM and reset cases,
// plus a CLK_DIV=4 instance for prescaler hold/resume behaviour.
module tb_countdown_timer_bcd;

  logic CLOCK;
  logic rst_a;
  logic rst_b;

  countdown_timer_bcd_if a_if ();
  countdown_timer_bcd_if b_if ();

  countdown_timer_bcd dut_a (
    .CLOCK (CLOCK),
    .RESET (rst_a),
    .bus   (a_if.slave)
  );

  countdown_timer_bcd #(.CLK_DIV(4)) dut_b (
    .CLOCK (CLOCK),
    .RESET (rst_b),
    .bus   (b_if.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        rst;
    logic        start;
    logic        pause;
    logic        penalty;
    logic [15:0] dig;
    logic        run;
    logic        warn;
    logic        expd;
  } vec_t;

  vec_t        vecs [14];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_t;
  logic [15:0] exp_dig;

  // Independent digit model: decrement packed M:SS.d with borrow.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m, sd, su, d;
    {m, sd, su, d} = v;
    if (d != 0) d = d - 4'd1;
    else begin
      d = 4'd9;
      if (su != 0) su = su - 4'd1;
      else begin
        su = 4'd9;
        if (sd != 0) sd = sd - 4'd1;
        else begin
          sd = 4'd5;
          m  = m - 4'd1;
        end
      end
    end
    return {m, sd, su, d};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.START = 1'b0; a_if.PAUSE = 1'b0; a_if.PENALTY = 1'b0;
    b_if.START = 1'b0; b_if.PAUSE = 1'b0; b_if.PENALTY = 1'b0;
  endtask

  task automatic check(input logic sel_b, input string nm, input logic [15:0] dig,
                       input logic run, input logic warn, input logic expd, input bit verbose);
    logic [15:0] ad;
    logic [2:0]  af;
    if (sel_b) begin
      ad = {b_if.MINUTOS, b_if.SEGUNDOS_DECIMOS, b_if.SEGUNDOS_UNIDADE, b_if.DECIMOS};
      af = {b_if.RUNNING, b_if.WARNING, b_if.TEMPO_ACABOU};
    end else begin
      ad = {a_if.MINUTOS, a_if.SEGUNDOS_DECIMOS, a_if.SEGUNDOS_UNIDADE, a_if.DECIMOS};
      af = {a_if.RUNNING, a_if.WARNING, a_if.TEMPO_ACABOU};
    end
    n_checks++;
    if (ad !== dig || af !== {run, warn, expd}) begin
      n_fail++;
      $display("FAIL %s: got digits %h run/warn/exp %b, expected digits %h run/warn/exp %b",
               nm, ad, af, dig, {run, warn, expd});
    end else if (verbose) begin
      $display("ok   %s: digits %h run/warn/exp %b", nm, ad, af);
    end
  endtask

  // Advance dut_a n cycles in RUN, checking every cycle against the model.
  task automatic run_a(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      step();
      exp_t   = exp_t - 1;
      exp_dig = bcd_dec(exp_dig);
      check(1'b0, nm, exp_dig, exp_t != 0, (exp_t <= 100) && (exp_t != 0), exp_t == 0, 1'b0);
    end
    $display("run  %s: %0d cycles, digits now %h", nm, n, exp_dig);
  endtask

  task automatic start_a();
    a_if.START = 1'b1;
    step();
    a_if.START = 1'b0;
    exp_t   = 1200;
    exp_dig = 16'h2000;
    check(1'b0, "start_a", 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_a(input string nm);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check(1'b0, nm, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    //           rst   start pause pen   digits    run   warn  exp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0}; // penalty in IDLE
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0}; // pause in IDLE
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b0, 1'b0}; // IDLE->RUN
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1599, 1'b1, 1'b0, 1'b0}; // first tick
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1599, 1'b0, 1'b0, 1'b0}; // start+pause in RUN
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1599, 1'b0, 1'b0, 1'b0}; // frozen
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1599, 1'b0, 1'b0, 1'b0}; // start+pause in PAUSED
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1499, 1'b0, 1'b0, 1'b0}; // penalty in PAUSED
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1499, 1'b1, 1'b0, 1'b0}; // resume
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h1498, 1'b1, 1'b0, 1'b0}; // tick
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1397, 1'b1, 1'b0, 1'b0}; // penalty + tick
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0}; // reset
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b0, 1'b0}; // start+penalty in IDLE
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0}; // reset

    clear_inputs();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    check(1'b0, "reset_a", 16'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
    check(1'b1, "reset_b", 16'h2000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full countdown with both borrow boundaries checked explicitly.
    start_a();
    run_a(600, "t1_to_1min");
    check(1'b0, "t1_at_1_00_0", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b1);
    run_a(1, "t1_borrow");
    check(1'b0, "t1_borrow_0_59_9", 16'h0599, 1'b1, 1'b0, 1'b0, 1'b1);
    run_a(599, "t1_to_zero");
    check(1'b0, "t1_expired", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step();
      check(1'b0, "t1_hold", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    $display("hold t1: 50 cycles after expiry");
    reset_a("t6_reset_in_expired");

    for (int i = 0; i < 14; i++) begin
      rst_a        = vecs[i].rst;
      a_if.START   = vecs[i].start;
      a_if.PAUSE   = vecs[i].pause;
      a_if.PENALTY = vecs[i].penalty;
      step();
      clear_inputs();
      rst_a = 1'b0;
      check(1'b0, $sformatf("vec%0d", i), vecs[i].dig, vecs[i].run, vecs[i].warn,
            vecs[i].expd, 1'b1);
    end

    // Reset while running at 1:10.0.
    start_a();
    run_a(500, "t6_to_700");
    check(1'b0, "t6_at_1_10_0", 16'h1100, 1'b1, 1'b0, 1'b0, 1'b1);
    reset_a("t6_reset_in_run");

    // Penalty larger than remaining time expires on the same edge.
    start_a();
    run_a(1150, "t3_to_50");
    check(1'b0, "t3_at_0_05_0", 16'h0050, 1'b1, 1'b1, 1'b0, 1'b1);
    a_if.PENALTY = 1'b1;
    step();
    clear_inputs();
    check(1'b0, "t3_penalty_expire", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    a_if.START   = 1'b1;
    a_if.PENALTY = 1'b1;
    step();
    clear_inputs();
    check(1'b0, "t3_expired_ignores", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    reset_a("t3_reset");

    // Penalty coinciding with a tick at 1:00.0, then warning threshold and 10 s borrow.
    start_a();
    run_a(600, "t3_to_600");
    check(1'b0, "t3_at_1_00_0", 16'h1000, 1'b1, 1'b0, 1'b0, 1'b1);
    a_if.PENALTY = 1'b1;
    step();
    clear_inputs();
    check(1'b0, "t3_penalty_tick", 16'h0499, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_t   = 499;
    exp_dig = 16'h0499;
    run_a(398, "t4_to_101");
    check(1'b0, "t4_at_101_no_warn", 16'h0101, 1'b1, 1'b0, 1'b0, 1'b1);
    run_a(1, "t4_to_100");
    check(1'b0, "t4_warn_rise", 16'h0100, 1'b1, 1'b1, 1'b0, 1'b1);
    run_a(1, "t4_to_99");
    check(1'b0, "t4_borrow_0_09_9", 16'h0099, 1'b1, 1'b1, 1'b0, 1'b1);

    // CLK_DIV=4: first tick 4 cycles after START, pause holds prescaler at 2.
    b_if.START = 1'b1;
    step();
    clear_inputs();
    check(1'b1, "b_start", 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step();
      check(1'b1, $sformatf("b_run_cycle%0d", i),
            (i >= 8) ? 16'h1598 : ((i >= 4) ? 16'h1599 : 16'h2000),
            1'b1, 1'b0, 1'b0, 1'b1);
    end
    b_if.PAUSE = 1'b1;
    step();
    clear_inputs();
    check(1'b1, "b_pause", 16'h1598, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      check(1'b1, "b_paused_hold", 16'h1598, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("hold b: 20 paused cycles");
    b_if.START = 1'b1;
    step();
    clear_inputs();
    check(1'b1, "b_resume", 16'h1598, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check(1'b1, "b_resume_plus1", 16'h1598, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check(1'b1, "b_resume_tick", 16'h1597, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check(1'b1, "b_before_next_tick", 16'h1597, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check(1'b1, "b_next_tick", 16'h1596, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
